// File: rtl/video_pkg.sv
// Shared video definitions: default raster geometry, output FSM states and
// the 4-pixel packed FIFO word used by both the capture and output sides.
package video_pkg;

  localparam int C_WIDTH  = 640;
  localparam int C_HEIGHT = 480;
  localparam int C_LSYNC  = 160;
  localparam int C_FSYNC  = 40;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // First pixel on screen lives in the most significant byte.
  typedef struct packed {
    logic [7:0] pixel_0;
    logic [7:0] pixel_1;
    logic [7:0] pixel_2;
    logic [7:0] pixel_3;
  } pix_word_t;

endpackage

// File: rtl/video_timing_gen.sv
// Raster position counters for video_out_gen. col/row hold the next position
// to be emitted and advance once per accepted pixel tick.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int p_WIDTH  = C_WIDTH,
  parameter int p_HEIGHT = C_HEIGHT,
  parameter int p_LSYNC  = C_LSYNC,
  parameter int p_FSYNC  = C_FSYNC,
  parameter int COL_W    = $clog2(p_WIDTH + p_LSYNC),
  parameter int ROW_W    = $clog2(p_HEIGHT + p_FSYNC)
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       adv,
  output logic [1:0] col_phase,
  output logic       active,
  output logic       frame_active,
  output logic       frame_end
);

  localparam int LAST_COL = p_WIDTH + p_LSYNC - 1;
  localparam int LAST_ROW = p_HEIGHT + p_FSYNC - 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Column/row counters, wrapping at the end of the line and of the frame.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col == COL_W'(LAST_COL)) begin
        col <= '0;
        row <= (row == ROW_W'(LAST_ROW)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign col_phase    = col[1:0];
  assign frame_active = 32'(row) < 32'(p_HEIGHT);
  assign active       = frame_active && (32'(col) < 32'(p_WIDTH));
  assign frame_end    = (col == COL_W'(LAST_COL)) && (row == ROW_W'(LAST_ROW));

endmodule

// File: rtl/video_out_gen.sv
// Video output generator: pulls packed 4-pixel words from a FWFT FIFO and
// streams them one byte per pixel tick with line/frame valid framing.
// Optional macro VIDEO_OUT_CHECK_EN adds simulation-only underflow checks.
module video_out_gen
  import video_pkg::*;
#(
  parameter int p_WIDTH  = C_WIDTH,
  parameter int p_HEIGHT = C_HEIGHT,
  parameter int p_LSYNC  = C_LSYNC,
  parameter int p_FSYNC  = C_FSYNC
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        pix_ce,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_r_e,
  output logic        line_valid,
  output logic        frame_valid,
  output logic [7:0]  pixel_out,
  output logic        underflow
);

  localparam int COL_W = $clog2(p_WIDTH + p_LSYNC);
  localparam int ROW_W = $clog2(p_HEIGHT + p_FSYNC);

  if ((p_WIDTH % 4) != 0) begin : g_width_check
    $error("video_out_gen: p_WIDTH must be a multiple of 4");
  end

  state_t     state;
  state_t     state_nxt;
  logic       tick;
  logic       active;
  logic       frame_active;
  logic       frame_end;
  logic       group_start;
  logic [1:0] col_phase;
  logic [23:0] rest_q;
  pix_word_t  head;

  assign head = pix_word_t'(fifo_data);

  video_timing_gen #(
    .p_WIDTH  (p_WIDTH),
    .p_HEIGHT (p_HEIGHT),
    .p_LSYNC  (p_LSYNC),
    .p_FSYNC  (p_FSYNC),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_timing (
    .clk          (clk),
    .nRST         (nRST),
    .adv          (tick),
    .col_phase    (col_phase),
    .active       (active),
    .frame_active (frame_active),
    .frame_end    (frame_end)
  );

  assign group_start = active && (col_phase == 2'd0);

  // A pop only happens on the first pixel of an active 4-pixel group.
  assign fifo_r_e = nRST && tick && group_start && !fifo_empty;

  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and emit strobe; a frame always runs to its last tick.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pix_ce && enable && !fifo_empty) begin
          tick      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (pix_ce) begin
          tick = 1'b1;
          if (frame_end && !enable) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output registers and word unpacking; an empty FIFO zeroes the whole group.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      pixel_out   <= 8'h00;
      underflow   <= 1'b0;
      rest_q      <= '0;
    end else if (pix_ce) begin
      if (!tick) begin
        line_valid  <= 1'b0;
        frame_valid <= 1'b0;
        pixel_out   <= 8'h00;
      end else begin
        line_valid  <= active;
        frame_valid <= frame_active;
        if (!active) begin
          pixel_out <= 8'h00;
        end else if (col_phase == 2'd0) begin
          if (fifo_empty) begin
            pixel_out <= 8'h00;
            rest_q    <= '0;
            underflow <= 1'b1;
          end else begin
            pixel_out <= head.pixel_0;
            rest_q    <= {head.pixel_1, head.pixel_2, head.pixel_3};
          end
        end else begin
          case (col_phase)
            2'd1:    pixel_out <= rest_q[23:16];
            2'd2:    pixel_out <= rest_q[15:8];
            default: pixel_out <= rest_q[7:0];
          endcase
        end
      end
    end
  end

`ifdef VIDEO_OUT_CHECK_EN
  // Simulation-only: halt on an underflow event or a pop from an empty FIFO.
  always @(posedge clk) begin
    if (nRST && tick && group_start && fifo_empty) begin
      $display("video_out_gen: FIFO underflow at an active group start");
      $stop;
    end
    if (fifo_r_e && fifo_empty) begin
      $display("video_out_gen: FIFO read while empty");
      $stop;
    end
  end
`endif

endmodule

// File: tb/tb_video_out_gen.sv
// Testbench for video_out_gen on a small 8x4 raster (2 blank ticks, 1 blank line).
module tb_video_out_gen;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int LS = 2;
  localparam int FS = 1;
  localparam int LL = W + LS;
  localparam int FR = LL * (H + FS);

  logic        clk = 1'b0;
  logic        nRST;
  logic        pix_ce;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_r_e;
  logic        line_valid;
  logic        frame_valid;
  logic [7:0]  pixel_out;
  logic        underflow;

  video_out_gen #(
    .p_WIDTH  (W),
    .p_HEIGHT (H),
    .p_LSYNC  (LS),
    .p_FSYNC  (FS)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .pix_ce      (pix_ce),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_r_e    (fifo_r_e),
    .line_valid  (line_valid),
    .frame_valid (frame_valid),
    .pixel_out   (pixel_out),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: raster index, FIFO contents as a queue, current word.
  logic [31:0] q[$];
  int          nw;
  bit          m_run;
  int          m_p;
  logic [31:0] m_word;
  bit          m_lv, m_fv, m_uf;
  logic [7:0]  m_pix;
  int          pops, lv_cnt, fv_low;

  task automatic model_reset();
    m_run = 0; m_p = 0; m_word = '0;
    m_lv = 0; m_fv = 0; m_uf = 0; m_pix = 8'h00;
  endtask

  task automatic clr_counts();
    pops = 0; lv_cnt = 0; fv_low = 0;
  endtask

  task automatic top_up();
    if (q.size() < 4) begin
      for (int k = 0; k < 8; k++) begin
        q.push_back({8'(nw * 4), 8'(nw * 4 + 1), 8'(nw * 4 + 2), 8'(nw * 4 + 3)});
        nw++;
      end
    end
  endtask

  // One clock: drive from the model FIFO, check pop before the edge, outputs after.
  task automatic mcycle(input bit pce, input bit en, input bit block);
    int col, row;
    bit act, tick, exp_re, got_re;
    pix_ce     = pce;
    enable     = en;
    fifo_empty = block || (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : $urandom;
    col    = m_p % LL;
    row    = m_p / LL;
    act    = (col < W) && (row < H);
    tick   = pce && (m_run || (en && !fifo_empty));
    exp_re = tick && act && (col % 4 == 0) && !fifo_empty;
    #1;
    got_re = fifo_r_e;
    check("fifo_r_e", got_re, exp_re);
    if (got_re) pops++;
    @(posedge clk);
    #1;
    if (pce) begin
      if (!tick) begin
        m_lv = 0; m_fv = 0; m_pix = 8'h00;
      end else begin
        m_lv = act;
        m_fv = (row < H);
        if (act && (col % 4 == 0)) begin
          if (fifo_empty) begin
            m_word = '0;
            m_uf   = 1;
          end else begin
            m_word = q.pop_front();
          end
        end
        m_pix = act ? m_word[8 * (3 - col % 4) +: 8] : 8'h00;
        m_run = !((m_p == FR - 1) && !en);
        m_p   = (m_p + 1) % FR;
      end
      if (line_valid) lv_cnt++;
      if (!frame_valid) fv_low++;
    end
    check("line_valid", line_valid, m_lv);
    check("frame_valid", frame_valid, m_fv);
    check("pixel_out", pixel_out, m_pix);
    check("underflow", underflow, m_uf);
    @(negedge clk);
  endtask

  typedef struct {
    bit          pce;
    bit          en;
    bit          emp;
    logic [31:0] data;
    bit          re;
    bit          lv;
    bit          fv;
    logic [7:0]  pix;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{0, 1, 0, 32'hA1B2C3D4, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 0, 0, 32'hA1B2C3D4, 0, 0, 0, 8'h00};
    tbl[2]  = '{1, 1, 1, 32'hA1B2C3D4, 0, 0, 0, 8'h00};
    tbl[3]  = '{1, 1, 0, 32'hA1B2C3D4, 1, 1, 1, 8'hA1};
    tbl[4]  = '{0, 1, 0, 32'h11223344, 0, 1, 1, 8'hA1};
    tbl[5]  = '{1, 0, 0, 32'h11223344, 0, 1, 1, 8'hB2};
    tbl[6]  = '{1, 1, 0, 32'h11223344, 0, 1, 1, 8'hC3};
    tbl[7]  = '{1, 1, 0, 32'h11223344, 0, 1, 1, 8'hD4};
    tbl[8]  = '{1, 1, 0, 32'h11223344, 1, 1, 1, 8'h11};
    tbl[9]  = '{1, 1, 0, 32'h55667788, 0, 1, 1, 8'h22};
    tbl[10] = '{1, 1, 0, 32'h55667788, 0, 1, 1, 8'h33};
    tbl[11] = '{1, 1, 0, 32'h55667788, 0, 1, 1, 8'h44};
    tbl[12] = '{1, 1, 0, 32'h55667788, 0, 0, 1, 8'h00};
    tbl[13] = '{1, 1, 0, 32'h55667788, 0, 0, 1, 8'h00};
    tbl[14] = '{1, 1, 0, 32'h55667788, 1, 1, 1, 8'h55};

    nw = 0;
    model_reset();
    clr_counts();
    nRST = 1'b0; pix_ce = 1'b0; enable = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    repeat (3) @(negedge clk);
    check("rst line_valid", line_valid, 0);
    check("rst frame_valid", frame_valid, 0);
    check("rst pixel_out", pixel_out, 0);
    check("rst underflow", underflow, 0);
    check("rst fifo_r_e", fifo_r_e, 0);
    nRST = 1'b1;
    @(negedge clk);

    // Directed start-up vectors.
    for (int i = 0; i < 15; i++) begin
      pix_ce = tbl[i].pce; enable = tbl[i].en;
      fifo_empty = tbl[i].emp; fifo_data = tbl[i].data;
      #1;
      check($sformatf("tbl%0d fifo_r_e", i), fifo_r_e, tbl[i].re);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d line_valid", i), line_valid, tbl[i].lv);
      check($sformatf("tbl%0d frame_valid", i), frame_valid, tbl[i].fv);
      check($sformatf("tbl%0d pixel_out", i), pixel_out, tbl[i].pix);
      check($sformatf("tbl%0d underflow", i), underflow, 0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a line.
    pix_ce = 1'b1; enable = 1'b1; fifo_empty = 1'b0; fifo_data = 32'hDEADBEEF;
    #2 nRST = 1'b0;
    #1;
    check("async line_valid", line_valid, 0);
    check("async frame_valid", frame_valid, 0);
    check("async pixel_out", pixel_out, 0);
    check("async fifo_r_e", fifo_r_e, 0);
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
    q.delete();
    repeat (5) mcycle(1, 0, 0);
    repeat (5) mcycle(1, 1, 0);

    // Two full frames, pixel tick every clock.
    clr_counts();
    for (int i = 0; i < 2 * FR; i++) begin
      top_up();
      mcycle(1, 1, 0);
    end
    check("two frames line_valid ticks", lv_cnt, 2 * W * H);
    check("two frames pops", pops, 2 * W * H / 4);
    check("two frames frame_valid low", fv_low, 2 * LL * FS);

    // Pixel tick every 4th clock, one frame.
    clr_counts();
    for (int i = 0; i < 4 * FR; i++) begin
      top_up();
      mcycle(i % 4 == 0, 1, 0);
    end
    check("slow ce line_valid ticks", lv_cnt, W * H);
    check("slow ce pops", pops, W * H / 4);

    // FIFO empty at row 1 col 4.
    for (int i = 0; i < 2 * FR && m_p != LL + 4; i++) begin
      top_up();
      mcycle(1, 1, 0);
    end
    check("reach row1 col4", m_p, LL + 4);
    clr_counts();
    top_up();
    mcycle(1, 1, 1);
    for (int i = 1; i < FR; i++) begin
      top_up();
      mcycle(1, 1, 0);
    end
    check("underflow frame line_valid ticks", lv_cnt, W * H);
    check("underflow frame pops", pops, W * H / 4 - 1);
    check("underflow sticky", underflow, 1);

    // Enable dropped at row 1: frame completes, then idle.
    for (int i = 0; i < 2 * FR && m_p != LL; i++) begin
      top_up();
      mcycle(1, 1, 0);
    end
    check("reach row1 col0", m_p, LL);
    clr_counts();
    for (int i = 0; i < FR; i++) begin
      top_up();
      mcycle(1, 0, 0);
    end
    check("drop tail line_valid ticks", lv_cnt, (H - 1) * W);
    check("drop tail pops", pops, (H - 1) * W / 4);
    clr_counts();
    for (int i = 0; i < FR; i++) begin
      top_up();
      mcycle(1, 0, 0);
    end
    check("idle line_valid ticks", lv_cnt, 0);
    check("idle pops", pops, 0);
    check("idle frame_valid", frame_valid, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (q.size() < 3 && $urandom_range(0, 3) == 0) top_up();
      mcycle(1'($urandom_range(0, 1)), $urandom_range(0, 15) != 0,
             $urandom_range(0, 11) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_out_gen.md
VIDEO_OUT_GEN -- requirements
Module: video_out_gen

Interface
REQ-001 SHALL have parameter p_WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter p_HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter p_LSYNC, default 160, blank pixel ticks after each line.
REQ-004 SHALL have parameter p_FSYNC, default 40, blank lines after each frame.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pix_ce  input  1  one-clk pixel-tick strobe (e.g. 25 MHz rate inside the 100 MHz clk).
REQ-008 SHALL have port enable  input  1  start/continue frame generation.
REQ-009 SHALL have port fifo_empty  input  1  pixel FIFO empty.
REQ-010 SHALL have port fifo_data  input  32  FIFO head word, first-word-fall-through.
REQ-011 SHALL have port fifo_r_e  output  1  FIFO pop, one clk wide.
REQ-012 SHALL have port line_valid  output  1  active pixel on pixel_out.
REQ-013 SHALL have port frame_valid  output  1  active frame.
REQ-014 SHALL have port pixel_out  output  8  pixel value.
REQ-015 SHALL have port underflow  output  1  sticky FIFO-underflow flag.

Function
REQ-016 SHALL hold counters col (0..p_WIDTH+p_LSYNC-1) and row (0..p_HEIGHT+p_FSYNC-1) giving the next position to emit; they advance only on clk edges with pix_ce=1.
REQ-017 SHALL implement states S_IDLE and S_RUN; S_IDLE -> S_RUN on a pix_ce cycle with enable=1 and fifo_empty=0, emitting position (0,0) on that tick.
REQ-018 In S_RUN, on each pix_ce cycle, SHALL register line_valid=(col<p_WIDTH && row<p_HEIGHT) and frame_valid=(row<p_HEIGHT) for the emitted position; outputs hold between ticks.
REQ-019 SHALL wrap col at p_WIDTH+p_LSYNC-1 to 0 with row+1; row wraps at p_HEIGHT+p_FSYNC-1 to 0.
REQ-020 At frame end (last tick of row p_HEIGHT+p_FSYNC-1): enable=1 -> continue in S_RUN at (0,0); enable=0 -> S_IDLE, outputs 0; enable changes mid-frame SHALL not truncate the frame.
REQ-021 Word unpack: on active tick with col%4==0, SHALL drive pixel_out<=fifo_data[31:24] and latch fifo_data[23:0]; col%4==1,2,3 SHALL emit bits [23:16],[15:8],[7:0] of the latched word.
REQ-022 fifo_r_e SHALL be combinational = pix_ce & S_RUN-or-entering & active & col%4==0 & ~fifo_empty; exactly one pop per 4 active pixels, p_WIDTH/4 per line.
REQ-023 Underflow: fifo_empty=1 at a col%4==0 active tick SHALL emit 0x00 for those 4 pixels, no pop, set underflow=1 until reset; timing counters unaffected.
REQ-024 Blank ticks SHALL drive pixel_out=0x00.
REQ-025 p_WIDTH SHALL be a multiple of 4 (elaboration-time check).

Reset
REQ-026 nRST=0 SHALL immediately force S_IDLE, col=row=0, line_valid=frame_valid=0, pixel_out=0, underflow=0, latched word=0; fifo_r_e=0 while in reset.
REQ-027 Reset mid-line SHALL discard the partial word; restart needs REQ-017 conditions.

Configuration
REQ-028 Macro VIDEO_OUT_CHECK_EN defined: simulation-only $display message and $stop on each underflow event and on fifo_r_e with fifo_empty=1; undefined: only the underflow flag, no simulation checks, identical synthesised logic.

Structure
REQ-029 Package video_pkg SHALL hold the p_WIDTH/p_HEIGHT/p_LSYNC/p_FSYNC defaults, the state enum, and the 4-pixel packed word typedef (pixel_0 in [31:24]), shared with the capture side.
REQ-030 Sub-module video_timing_gen SHALL own col/row counters and active/frame-end decode; video_out_gen owns state, unpacking and FIFO control.

Verification
REQ-031 Reset: nRST low mid-frame -> all outputs 0 same cycle; after release no line_valid until enable=1 and FIFO non-empty.
REQ-032 Full frame, pix_ce every clk, FIFO holding 76800 incrementing words -> exactly 307200 line_valid ticks, bytes in MSB-first order, 160-tick gaps, frame_valid low 32000 ticks, 76800 pops.
REQ-033 pix_ce every 4th clk, p_WIDTH=8,p_HEIGHT=4,p_LSYNC=2,p_FSYNC=1 -> same pixel sequence, each fifo_r_e exactly 1 clk, 2 pops per line.
REQ-034 FIFO empties at row 10 col 64 -> pixels 64..67 = 0x00, underflow=1 sticky, line/frame timing unchanged, refill resumes at col 68.
REQ-035 enable dropped at row 100 -> frame completes incl. 40 blank lines, then S_IDLE, no further pops.
REQ-036 VIDEO_OUT_CHECK_EN defined with REQ-034 stimulus -> simulation stops with message; undefined -> runs to completion.
